// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and mode type.
package imm_ext_pkg;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t MODE_ZERO   = 2'b00;
    localparam imm_mode_t MODE_SIGN   = 2'b01;
    localparam imm_mode_t MODE_UPPER  = 2'b10;
    localparam imm_mode_t MODE_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_fifo.sv
// Generic synchronous FIFO with flush, valid/ready on both sides, no pass-through path.
// Pointers wrap by explicit compare so DEPTH need not be a power of two.
module imm_ext_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Handshake: a transfer happens on a side exactly when its valid and ready are both high
    // at a rising edge; ready/valid depend only on count, so nothing passes through combinationally.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; stale entries are hidden by the out_valid gating above.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Immediate-extension stage: zero/sign/upper(/branch) extension feeding a DEPTH-entry FIFO.
// Optional feature macro: IMM_EXT_BRANCH_EN (mode 11 = branch word offset instead of illegal).
module imm_extend_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  imm_mode_t        in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic [OUT_W:0]   fifo_out;

    assign zero_ext = {{(OUT_W - IN_W){1'b0}}, in_imm};
    assign sign_ext = {{(OUT_W - IN_W){in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_mode)
            MODE_ZERO:  ext_data = zero_ext;
            MODE_SIGN:  ext_data = sign_ext;
            MODE_UPPER: ext_data = zero_ext << (OUT_W - IN_W);
            default: begin
`ifdef IMM_EXT_BRANCH_EN
                ext_data = sign_ext << 2;
`else
                ext_err  = 1'b1;
`endif
            end
        endcase
    end

    imm_ext_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({ext_err, ext_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out)
    );

    assign out_data = fifo_out[OUT_W-1:0];
    assign out_err  = fifo_out[OUT_W];

endmodule
